kernel_struct_loader: RTL and testbench
=======================================

Name: kernel_struct_loader

Overview:
Upstream feeder of the convolution control FSM (fsm_rn). Fetches per-filter bias and per-channel kernel weights from a synchronous weight memory. Presents them as a parallel 9-entry kernel plus bias, with a struct_ready level. Advances on the FSM's next_channel / next_filter pulses and walks all filters × channels of one layer per start.

Parameters:
ADDRESS_BITS, 16, width of the weight-memory address bus.
KERNEL_MAX, 9, number of kernel entries presented; kernel_size_2 is clamped to this value.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
start  in  1  one-cycle pulse; begins a layer; ignored unless in IDLE or DONE.
w_base  in  ADDRESS_BITS  weight-memory address of filter 0's bias word.
amount_channels  in  8  input channels per filter; sampled on start.
amount_filters  in  8  filters in layer; sampled on start.
kernel_size_2  in  8  weights per channel kernel; sampled on start; clamped to KERNEL_MAX.
next_channel  in  1  FSM pulse: current channel consumed.
next_filter  in  1  FSM pulse: current filter finished.
w_rd  out  1  weight-memory read enable.
w_addr  out  ADDRESS_BITS  weight-memory read address.
w_data  in  8  read data, valid the cycle after w_rd.
kernel  out  8 × [0:KERNEL_MAX-1]  kernel weights for the current filter/channel.
bias  out  8  current filter bias.
struct_ready  out  1  level; kernel and bias are valid and stable.
filter_idx  out  8  current filter index.
channel_idx  out  8  current channel index.
busy  out  1  high in any state except IDLE and DONE.
done  out  1  high in DONE; cleared by start or reset.

Behaviour:
- Reset: all outputs 0, kernel entries 0, state IDLE. Reset mid-fetch aborts immediately; no pending read completes.
- Memory layout: K = min(kernel_size_2, KERNEL_MAX), S = amount_channels*K + 1.
  - Filter f base B = w_base + f*S.
  - Bias is at B; weight k of channel c is at B + 1 + c*K + k.
  - Address arithmetic is modulo 2^ADDRESS_BITS.
- States: IDLE, FETCH_BIAS, FETCH_W, READY, DONE.
- start in IDLE/DONE:
  - Latch config, filter_idx = channel_idx = 0, done = 0.
  - If amount_channels == 0 or amount_filters == 0, go to DONE.
  - Otherwise go to FETCH_BIAS.
- FETCH_BIAS: issue 1 read (bias address), then FETCH_W.
- FETCH_W:
  - Issue K reads on consecutive cycles, w_rd held high.
  - Data is captured one cycle after each read: bias first, then kernel[0..K-1].
  - kernel[K..KERNEL_MAX-1] forced to 0.
  - struct_ready is set on the same edge that captures the last word; state goes to READY.
- Latency: from the edge sampling start/next_filter to struct_ready high is K+2 edges (11 for K=9). From next_channel it is K+1 edges (10).
- READY: struct_ready = 1; outputs stable.
  - next_channel, with channel_idx < amount_channels-1: channel_idx++, struct_ready = 0 on that edge, go to FETCH_W (bias retained).
  - next_channel on the last channel: ignored.
  - next_filter, with filter_idx < amount_filters-1: filter_idx++, channel_idx = 0, struct_ready = 0, go to FETCH_BIAS.
  - next_filter on the last filter: struct_ready = 0, go to DONE.
  - next_channel and next_filter in the same cycle: next_filter wins.
- next_channel / next_filter outside READY are ignored. start while busy is ignored.
- kernel/bias retain their last values in DONE.
- w_rd = 0 and w_addr holds its last value whenever no read is issued.

Test Plan:
- Reset → all outputs 0. Drive rst = 0 mid-FETCH_W → w_rd = 0, state IDLE, struct_ready stays 0.
- Memory word = low byte of its address, w_base = 0x0100, channels = 2, filters = 2, K = 9; pulse start → reads at 0x0100..0x0109. struct_ready rises 11 edges after start with bias = 0x00, kernel = 0x01..0x09.
- From that READY, pulse next_channel → reads at 0x010A..0x0112. After 10 edges: kernel = 0x0A..0x12, bias still 0x00, channel_idx = 1.
- From that READY, pulse next_filter → filter base 0x0113. bias = 0x13, kernel = 0x14..0x1C, filter_idx = 1, channel_idx = 0. Second next_filter → done = 1, busy = 0.
- next_channel on the last channel → no read, no change. next_channel and next_filter in the same cycle → filter advances only.
- kernel_size_2 = 4 → kernel[4..8] = 0, 5 reads per filter load. amount_filters = 0 → done within 1 edge of start, w_rd never asserted.

Source files
------------

// File: rtl/kernel_struct_loader_if.sv
// Weight-memory read port used by kernel_struct_loader.
//   w_rd   : read enable, driven by the loader
//   w_addr : read address, driven by the loader
//   w_data : read data from the memory, valid the cycle after w_rd
interface kernel_struct_loader_if #(
  parameter int unsigned ADDRESS_BITS = 16
);
  logic                    w_rd;
  logic [ADDRESS_BITS-1:0] w_addr;
  logic [7:0]              w_data;

  modport master (output w_rd, output w_addr, input w_data);
  modport slave  (input w_rd, input w_addr, output w_data);
endinterface

// File: rtl/kernel_struct_loader.sv
// Fetches per-filter bias and per-channel kernel weights from a synchronous
// weight memory and presents them as a parallel kernel plus bias.
// Walks every filter x channel of a layer, advancing on FSM pulses.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : begins a layer (only in IDLE or DONE)
//   w_base          : address of filter 0's bias word
//   amount_channels : channels per filter   (sampled on start)
//   amount_filters  : filters in the layer  (sampled on start)
//   kernel_size_2   : weights per kernel    (sampled on start, clamped)
//   next_channel    : current channel consumed
//   next_filter     : current filter finished
//   wmem            : weight-memory read port (master side)
//   kernel, bias    : current kernel weights and filter bias
//   struct_ready    : kernel and bias valid and stable
//   filter_idx      : current filter index
//   channel_idx     : current channel index
//   busy, done      : layer in progress / layer finished
module kernel_struct_loader #(
  parameter int unsigned ADDRESS_BITS = 16,
  parameter int unsigned KERNEL_MAX   = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] w_base,
  input  logic [7:0]              amount_channels,
  input  logic [7:0]              amount_filters,
  input  logic [7:0]              kernel_size_2,
  input  logic                    next_channel,
  input  logic                    next_filter,
  kernel_struct_loader_if.master  wmem,
  output logic [7:0]              kernel [0:KERNEL_MAX-1],
  output logic [7:0]              bias,
  output logic                    struct_ready,
  output logic [7:0]              filter_idx,
  output logic [7:0]              channel_idx,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned AW = ADDRESS_BITS;
  localparam int unsigned KW = $clog2(KERNEL_MAX + 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_FETCH_BIAS = 3'd1;
  localparam logic [2:0] S_FETCH_W    = 3'd2;
  localparam logic [2:0] S_READY      = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  logic [2:0]    state,       state_nx;
  logic [KW-1:0] cfg_k,       cfg_k_nx;
  logic [7:0]    cfg_ch,      cfg_ch_nx;
  logic [7:0]    cfg_f,       cfg_f_nx;
  logic [AW-1:0] stride,      stride_nx;
  logic [AW-1:0] filt_base,   filt_base_nx;
  logic [AW-1:0] rd_addr,     rd_addr_nx;
  logic [KW-1:0] rd_left,     rd_left_nx;
  logic [KW-1:0] cap_idx,     cap_idx_nx;
  logic          cap_bias,    cap_bias_nx;
  logic          rd_d;
  logic          w_rd_q,      w_rd_nx;
  logic [AW-1:0] w_addr_q,    w_addr_nx;
  logic [7:0]    kernel_nx [0:KERNEL_MAX-1];
  logic [7:0]    bias_nx;
  logic          ready_nx;
  logic [7:0]    filter_idx_nx;
  logic [7:0]    channel_idx_nx;
  logic          busy_nx;
  logic          done_nx;

  logic [7:0]    k_clamp_c;
  logic [15:0]   prod_c;
  logic [AW-1:0] next_fbase_c;

  assign k_clamp_c    = (kernel_size_2 > 8'(KERNEL_MAX)) ? 8'(KERNEL_MAX) : kernel_size_2;
  assign prod_c       = 16'(amount_channels) * 16'(k_clamp_c);
  assign next_fbase_c = filt_base + stride;

  assign wmem.w_rd   = w_rd_q;
  assign wmem.w_addr = w_addr_q;

  // Next-state and next-output logic
  always_comb begin
    state_nx       = state;
    cfg_k_nx       = cfg_k;
    cfg_ch_nx      = cfg_ch;
    cfg_f_nx       = cfg_f;
    stride_nx      = stride;
    filt_base_nx   = filt_base;
    rd_addr_nx     = rd_addr;
    rd_left_nx     = rd_left;
    cap_idx_nx     = cap_idx;
    cap_bias_nx    = cap_bias;
    w_rd_nx        = 1'b0;
    w_addr_nx      = w_addr_q;
    kernel_nx      = kernel;
    bias_nx        = bias;
    ready_nx       = struct_ready;
    filter_idx_nx  = filter_idx;
    channel_idx_nx = channel_idx;
    done_nx        = done;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          cfg_k_nx       = KW'(k_clamp_c);
          cfg_ch_nx      = amount_channels;
          cfg_f_nx       = amount_filters;
          stride_nx      = AW'(prod_c) + AW'(1);
          filter_idx_nx  = 8'd0;
          channel_idx_nx = 8'd0;
          done_nx        = 1'b0;
          if (amount_channels == 8'd0 || amount_filters == 8'd0) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx     = S_FETCH_BIAS;
            w_rd_nx      = 1'b1;
            w_addr_nx    = w_base;
            filt_base_nx = w_base;
            rd_addr_nx   = w_base + AW'(1);
            cap_bias_nx  = 1'b1;
            cap_idx_nx   = '0;
            // Entries beyond the clamped kernel size are never written this layer
            for (int i = 0; i < KERNEL_MAX; i++) begin
              if (KW'(i) >= KW'(k_clamp_c)) kernel_nx[i] = 8'd0;
            end
          end
        end
      end

      S_FETCH_BIAS: begin
        state_nx = S_FETCH_W;
        if (cfg_k != '0) begin
          w_rd_nx    = 1'b1;
          w_addr_nx  = rd_addr;
          rd_addr_nx = rd_addr + AW'(1);
          rd_left_nx = cfg_k - KW'(1);
        end else begin
          rd_left_nx = '0;
        end
      end

      S_FETCH_W: begin
        if (rd_left != '0) begin
          w_rd_nx    = 1'b1;
          w_addr_nx  = rd_addr;
          rd_addr_nx = rd_addr + AW'(1);
          rd_left_nx = rd_left - KW'(1);
        end
      end

      S_READY: begin
        if (next_filter) begin
          ready_nx = 1'b0;
          if (filter_idx < cfg_f - 8'd1) begin
            state_nx       = S_FETCH_BIAS;
            filter_idx_nx  = filter_idx + 8'd1;
            channel_idx_nx = 8'd0;
            w_rd_nx        = 1'b1;
            w_addr_nx      = next_fbase_c;
            filt_base_nx   = next_fbase_c;
            rd_addr_nx     = next_fbase_c + AW'(1);
            cap_bias_nx    = 1'b1;
            cap_idx_nx     = '0;
          end else begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end
        end else if (next_channel && (channel_idx < cfg_ch - 8'd1)) begin
          channel_idx_nx = channel_idx + 8'd1;
          // Channel weights are contiguous, so rd_addr already points at the next channel
          if (cfg_k != '0) begin
            state_nx    = S_FETCH_W;
            ready_nx    = 1'b0;
            w_rd_nx     = 1'b1;
            w_addr_nx   = rd_addr;
            rd_addr_nx  = rd_addr + AW'(1);
            rd_left_nx  = cfg_k - KW'(1);
            cap_bias_nx = 1'b0;
            cap_idx_nx  = '0;
          end
        end
      end

      default: state_nx = S_IDLE;
    endcase

    // Capture returning read data: bias first (filter loads), then kernel words
    if (state == S_FETCH_W && rd_d) begin
      if (cap_bias) begin
        bias_nx     = wmem.w_data;
        cap_bias_nx = 1'b0;
        if (cfg_k == '0) begin
          ready_nx = 1'b1;
          state_nx = S_READY;
        end
      end else begin
        for (int i = 0; i < KERNEL_MAX; i++) begin
          if (KW'(i) == cap_idx) kernel_nx[i] = wmem.w_data;
        end
        cap_idx_nx = cap_idx + KW'(1);
        if (cap_idx == cfg_k - KW'(1)) begin
          ready_nx = 1'b1;
          state_nx = S_READY;
        end
      end
    end

    busy_nx = (state_nx != S_IDLE) && (state_nx != S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cfg_k        <= '0;
      cfg_ch       <= '0;
      cfg_f        <= '0;
      stride       <= '0;
      filt_base    <= '0;
      rd_addr      <= '0;
      rd_left      <= '0;
      cap_idx      <= '0;
      cap_bias     <= 1'b0;
      rd_d         <= 1'b0;
      w_rd_q       <= 1'b0;
      w_addr_q     <= '0;
      for (int i = 0; i < KERNEL_MAX; i++) kernel[i] <= 8'd0;
      bias         <= 8'd0;
      struct_ready <= 1'b0;
      filter_idx   <= 8'd0;
      channel_idx  <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nx;
      cfg_k        <= cfg_k_nx;
      cfg_ch       <= cfg_ch_nx;
      cfg_f        <= cfg_f_nx;
      stride       <= stride_nx;
      filt_base    <= filt_base_nx;
      rd_addr      <= rd_addr_nx;
      rd_left      <= rd_left_nx;
      cap_idx      <= cap_idx_nx;
      cap_bias     <= cap_bias_nx;
      rd_d         <= w_rd_q;
      w_rd_q       <= w_rd_nx;
      w_addr_q     <= w_addr_nx;
      kernel       <= kernel_nx;
      bias         <= bias_nx;
      struct_ready <= ready_nx;
      filter_idx   <= filter_idx_nx;
      channel_idx  <= channel_idx_nx;
      busy         <= busy_nx;
      done         <= done_nx;
    end
  end

endmodule

// File: tb/tb_kernel_struct_loader.sv
// Self-checking bench for kernel_struct_loader: a synchronous weight memory,
// a layer-walk reference model derived from the memory layout and timing
// rules, a per-cycle compare process, directed scenarios with literal
// expectations, and randomized layers.
module tb_kernel_struct_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] w_base;
  logic [7:0]  amount_channels;
  logic [7:0]  amount_filters;
  logic [7:0]  kernel_size_2;
  logic        next_channel;
  logic        next_filter;
  logic [7:0]  kernel [0:8];
  logic [7:0]  bias;
  logic        struct_ready;
  logic [7:0]  filter_idx;
  logic [7:0]  channel_idx;
  logic        busy;
  logic        done;

  kernel_struct_loader_if #(.ADDRESS_BITS(16)) mif ();

  kernel_struct_loader #(.ADDRESS_BITS(16), .KERNEL_MAX(9)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .w_base          (w_base),
    .amount_channels (amount_channels),
    .amount_filters  (amount_filters),
    .kernel_size_2   (kernel_size_2),
    .next_channel    (next_channel),
    .next_filter     (next_filter),
    .wmem            (mif),
    .kernel          (kernel),
    .bias            (bias),
    .struct_ready    (struct_ready),
    .filter_idx      (filter_idx),
    .channel_idx     (channel_idx),
    .busy            (busy),
    .done            (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous weight memory
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mif.w_rd) mif.w_data <= mem[mif.w_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 walking a layer, 2 done.  The current load began at
  // edge m_t0, issues m_n consecutive reads starting at m_a0, and is ready
  // once m_n+1 edges have passed.
  int cyc = 0;
  int m_mode, m_t0, m_n, m_a0, m_f, m_c;
  int m_ch, m_nf, m_k, m_base, m_bias;
  int m_kern [9];

  function automatic int clampk(input int ks);
    return (ks > 9) ? 9 : ks;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_t0 = cyc; m_n = 1; m_a0 = 0;
    m_f = 0; m_c = 0; m_bias = 0;
    for (int k = 0; k < 9; k++) m_kern[k] = 0;
  endtask

  task automatic model_load(input bit is_filter);
    int b;
    b = m_base + m_f * (m_ch * m_k + 1);
    m_t0 = cyc;
    m_n  = is_filter ? m_k + 1 : m_k;
    m_a0 = is_filter ? b : b + 1 + m_c * m_k;
    if (is_filter) m_bias = int'(mem[16'(b)]);
    for (int k = 0; k < 9; k++)
      m_kern[k] = (k < m_k) ? int'(mem[16'(b + 1 + m_c * m_k + k)]) : 0;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst) begin : model_step
    bit rp;
    if (!rst) begin
      model_reset();
    end else begin
      rp = (m_mode == 1) && ((cyc - m_t0) >= m_n + 1);
      cyc++;
      case (m_mode)
        1: begin
          if (rp) begin
            if (next_filter) begin
              if (m_f < m_nf - 1) begin
                m_f++; m_c = 0; model_load(1'b1);
              end else begin
                m_mode = 2;
              end
            end else if (next_channel && m_c < m_ch - 1) begin
              m_c++; model_load(1'b0);
            end
          end
        end
        default: begin
          if (start) begin
            m_ch = int'(amount_channels); m_nf = int'(amount_filters);
            m_k = clampk(int'(kernel_size_2)); m_base = int'(w_base);
            m_f = 0; m_c = 0;
            if (m_ch == 0 || m_nf == 0) m_mode = 2;
            else begin m_mode = 1; model_load(1'b1); end
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    int d, e_addr;
    bit e_ready, e_rd;
    if (chk_en) begin
      d       = cyc - m_t0;
      e_ready = (m_mode == 1) && (d >= m_n + 1);
      e_rd    = (m_mode == 1) && (d < m_n);
      e_addr  = (m_a0 + ((d > m_n - 1) ? m_n - 1 : d)) & 16'hFFFF;
      check("w_rd", int'(mif.w_rd), int'(e_rd));
      check("w_addr", int'(mif.w_addr), e_addr);
      check("struct_ready", int'(struct_ready), int'(e_ready));
      check("busy", int'(busy), int'(m_mode == 1));
      check("done", int'(done), int'(m_mode == 2));
      check("filter_idx", int'(filter_idx), m_f);
      check("channel_idx", int'(channel_idx), m_c);
      if (!(m_mode == 1 && !e_ready)) begin
        check("bias", int'(bias), m_bias);
        for (int k = 0; k < 9; k++)
          check($sformatf("kernel[%0d]", k), int'(kernel[k]), m_kern[k]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input bit s, input bit nc, input bit nf);
    @(negedge clk);
    start = s; next_channel = nc; next_filter = nf;
    @(negedge clk);
    start = 1'b0; next_channel = 1'b0; next_filter = 1'b0;
  endtask

  task automatic wait_ready(output int lat, output int nrd);
    lat = 0;
    nrd = int'(mif.w_rd);
    while (!struct_ready && lat < 60) begin
      @(negedge clk);
      lat++;
      if (mif.w_rd) nrd++;
    end
  endtask

  task automatic set_cfg(input int base, input int ch, input int nf, input int ks);
    w_base = 16'(base); amount_channels = 8'(ch);
    amount_filters = 8'(nf); kernel_size_2 = 8'(ks);
  endtask

  initial begin : main
    int lat, nrd;
    rst = 1'b1; start = 1'b0; next_channel = 1'b0; next_filter = 1'b0;
    set_cfg(0, 0, 0, 0);
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_w_addr", int'(mif.w_addr), 0);
    check("rst_kernel0", int'(kernel[0]), 0);
    @(posedge clk); #3 rst = 1'b1;

    // Filter 0, channel 0 load
    set_cfg('h0100, 2, 2, 9);
    pulse(1'b1, 1'b0, 1'b0);
    check("s1_first_rd", int'(mif.w_rd), 1);
    check("s1_first_addr", int'(mif.w_addr), 'h0100);
    wait_ready(lat, nrd);
    check("s1_latency", lat, 11);
    check("s1_reads", nrd, 10);
    check("s1_bias", int'(bias), 'h00);
    check("s1_k0", int'(kernel[0]), 'h01);
    check("s1_k8", int'(kernel[8]), 'h09);

    // Channel 1
    pulse(1'b0, 1'b1, 1'b0);
    check("s2_first_addr", int'(mif.w_addr), 'h010A);
    wait_ready(lat, nrd);
    check("s2_latency", lat, 10);
    check("s2_reads", nrd, 9);
    check("s2_k0", int'(kernel[0]), 'h0A);
    check("s2_k8", int'(kernel[8]), 'h12);
    check("s2_bias", int'(bias), 'h00);
    check("s2_chan", int'(channel_idx), 1);

    // next_channel on the last channel is ignored
    pulse(1'b0, 1'b1, 1'b0);
    check("s3_no_rd", int'(mif.w_rd), 0);
    repeat (3) @(negedge clk);
    check("s3_chan", int'(channel_idx), 1);
    check("s3_ready", int'(struct_ready), 1);

    // Both pulses together: filter advances
    pulse(1'b0, 1'b1, 1'b1);
    check("s4_first_addr", int'(mif.w_addr), 'h0113);
    wait_ready(lat, nrd);
    check("s4_latency", lat, 11);
    check("s4_bias", int'(bias), 'h13);
    check("s4_k0", int'(kernel[0]), 'h14);
    check("s4_k8", int'(kernel[8]), 'h1C);
    check("s4_filter", int'(filter_idx), 1);
    check("s4_chan", int'(channel_idx), 0);

    // Last filter finished
    pulse(1'b0, 1'b0, 1'b1);
    check("s5_done", int'(done), 1);
    check("s5_busy", int'(busy), 0);
    check("s5_ready", int'(struct_ready), 0);

    // Clamped-short kernel
    set_cfg('h0200, 1, 1, 4);
    pulse(1'b1, 1'b0, 1'b0);
    check("s6_done_clr", int'(done), 0);
    wait_ready(lat, nrd);
    check("s6_latency", lat, 6);
    check("s6_reads", nrd, 5);
    check("s6_k3", int'(kernel[3]), 'h04);
    check("s6_k4", int'(kernel[4]), 0);
    check("s6_k8", int'(kernel[8]), 0);
    pulse(1'b0, 1'b0, 1'b1);

    // Empty layer
    set_cfg('h0300, 3, 0, 9);
    pulse(1'b1, 1'b0, 1'b0);
    check("s7_done", int'(done), 1);
    check("s7_no_rd", int'(mif.w_rd), 0);
    repeat (3) @(negedge clk);

    // Reset in the middle of a weight fetch
    set_cfg('h0400, 1, 1, 9);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("s8_rd", int'(mif.w_rd), 0);
    check("s8_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst = 1'b1;
    repeat (15) @(negedge clk);
    check("s8_ready", int'(struct_ready), 0);
    check("s8_kernel0", int'(kernel[0]), 0);

    // Randomized layers over random memory contents
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int l = 0; l < 40; l++) begin
      set_cfg(int'($urandom_range(0, 65535)),
              ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3)),
              ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3)),
              int'($urandom_range(1, 15)));
      pulse(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 800 && m_mode != 2; c++) begin
        @(negedge clk);
        next_channel = ($urandom_range(0, 3) == 0);
        next_filter  = ($urandom_range(0, 5) == 0);
        start        = ($urandom_range(0, 15) == 0);
      end
      start = 1'b0; next_channel = 1'b0; next_filter = 1'b0;
      check("layer_done", int'(m_mode == 2), 1);
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
